// File: rtl/datapath_mon_pkg.sv
// Shared types and helpers for the Datapath run monitor.
package datapath_mon_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Address width for n entries (at least 1 bit).
  function automatic int clog2w(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/datapath_run_monitor_trace_ram.sv
// Trace storage: one synchronous write port, one asynchronous read port, no reset.
module trace_ram #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/datapath_run_monitor.sv
// Run controller and monitor: holds the Datapath in reset, runs it, detects a
// settled result or a timeout, keeps a trace of recent results and grades the
// final value against the expected one.
module datapath_run_monitor
  import datapath_mon_pkg::*;
#(
  parameter int WIDTH         = 32,
  parameter int RESET_CYCLES  = 10,
  parameter int STABLE_CYCLES = 4,
  parameter int TIMEOUT       = 1024,
  parameter int DEPTH         = 16,
  parameter int CW            = 16,
  localparam int AW           = clog2w(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] expected,
  input  logic [WIDTH-1:0] dut_result,
  output logic             dut_reset,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             timed_out,
  output logic [CW-1:0]    cycle_count,
  output logic [WIDTH-1:0] final_result,
  input  logic [AW-1:0]    trace_addr,
  output logic [WIDTH-1:0] trace_data,
  output logic [AW:0]      trace_count
);

  localparam int TW = AW + 1;
  localparam int HW = clog2w(RESET_CYCLES + 1);
  localparam int SW = clog2w(STABLE_CYCLES + 1);

  localparam logic [HW-1:0] HOLD_LOAD   = HW'(RESET_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST     = CW'(TIMEOUT - 1);
  localparam logic [TW-1:0] TC_MAX      = TW'(DEPTH);
  localparam logic [SW-1:0] STABLE_SAT  = SW'(STABLE_CYCLES);
  localparam logic [SW-1:0] STABLE_LAST = SW'(STABLE_CYCLES - 1);

  state_t           state, state_nxt;
  logic [HW-1:0]    hold_cnt;
  logic [CW-1:0]    cycle_q;
  logic [WIDTH-1:0] final_q;
  logic [WIDTH-1:0] exp_q;
  logic [AW-1:0]    wptr;
  logic [TW-1:0]    tcount;
  logic [SW-1:0]    stable_cnt;
  logic [SW-1:0]    stable_inc;
  logic             pass_q, to_q;

  logic             accept, hold_last, same, complete, timeout_hit, in_run;
  logic [AW-1:0]    rd_idx;

  assign in_run      = (state == RUN);
  assign accept      = start && ((state == IDLE) || (state == DONE));
  assign hold_last   = (hold_cnt == '0);
  // The very first RUN sample has nothing to compare against.
  assign same        = (dut_result == final_q) && (tcount != '0);
  assign stable_inc  = (stable_cnt == STABLE_SAT) ? stable_cnt : stable_cnt + SW'(1);
  assign complete    = in_run && same && (stable_inc >= STABLE_LAST);
  assign timeout_hit = in_run && (cycle_q == TO_LAST);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; completion takes priority over timeout.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = HOLD;
      HOLD:    if (hold_last) state_nxt = RUN;
      RUN:     if (complete || timeout_hit) state_nxt = DONE;
      DONE:    if (start) state_nxt = HOLD;
      default: state_nxt = IDLE;
    endcase
  end

  // Hold counter, run statistics, trace pointer and verdict.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_cnt   <= '0;
      cycle_q    <= '0;
      final_q    <= '0;
      exp_q      <= '0;
      wptr       <= '0;
      tcount     <= '0;
      stable_cnt <= '0;
      pass_q     <= 1'b0;
      to_q       <= 1'b0;
    end else if (accept) begin
      exp_q      <= expected;
      hold_cnt   <= HOLD_LOAD;
      cycle_q    <= '0;
      tcount     <= '0;
      stable_cnt <= '0;
      pass_q     <= 1'b0;
      to_q       <= 1'b0;
    end else if (state == HOLD) begin
      if (!hold_last) hold_cnt <= hold_cnt - HW'(1);
    end else if (in_run) begin
      cycle_q    <= cycle_q + CW'(1);
      wptr       <= wptr + AW'(1);
      tcount     <= (tcount == TC_MAX) ? tcount : tcount + TW'(1);
      final_q    <= dut_result;
      stable_cnt <= same ? stable_inc : '0;
      if (complete) begin
        pass_q <= (dut_result == exp_q);
        to_q   <= 1'b0;
      end else if (timeout_hit) begin
        pass_q <= 1'b0;
        to_q   <= 1'b1;
      end
    end
  end

  // Newest entry sits just behind the write pointer.
  assign rd_idx = wptr - AW'(1) - trace_addr;

  trace_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_trace (
    .clk   (clk),
    .we    (in_run),
    .waddr (wptr),
    .wdata (dut_result),
    .raddr (rd_idx),
    .rdata (trace_data)
  );

  // The Datapath only runs in RUN; reset follows state, so it asserts
  // asynchronously with the monitor's own reset.
  assign dut_reset    = !in_run;
  assign busy         = (state == HOLD) || in_run;
  assign done         = (state == DONE);
  assign pass         = pass_q;
  assign timed_out    = to_q;
  assign cycle_count  = cycle_q;
  assign final_result = final_q;
  assign trace_count  = tcount;

endmodule

// File: tb/tb_datapath_run_monitor.sv
// Directed bench for datapath_run_monitor with a stub Datapath.
module tb_datapath_run_monitor;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] expected;
  logic [31:0] dut_result;
  logic        dut_reset;
  logic        busy, done, pass, timed_out;
  logic [15:0] cycle_count;
  logic [31:0] final_result;
  logic [3:0]  trace_addr;
  logic [31:0] trace_data;
  logic [4:0]  trace_count;

  int n_cmp = 0;
  int n_bad = 0;
  int mode  = 0;
  logic [31:0] k;
  int hold_n, run_n;

  datapath_run_monitor #(
    .WIDTH(32), .RESET_CYCLES(10), .STABLE_CYCLES(4),
    .TIMEOUT(64), .DEPTH(16), .CW(16)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .expected(expected),
    .dut_result(dut_result), .dut_reset(dut_reset), .busy(busy),
    .done(done), .pass(pass), .timed_out(timed_out),
    .cycle_count(cycle_count), .final_result(final_result),
    .trace_addr(trace_addr), .trace_data(trace_data),
    .trace_count(trace_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stub Datapath: step counter restarts while held in reset.
  always @(posedge clk) begin
    if (dut_reset) k <= 32'd0;
    else           k <= k + 32'd1;
  end

  always_comb begin
    dut_result = 32'd0;
    case (mode)
      0: dut_result = (k < 32'd3) ? k + 32'd1 : 32'h2A;
      1: dut_result = k;
      2: dut_result = (k < 32'd20) ? k : 32'd19;
      default: dut_result = 32'd0;
    endcase
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, want);
    end
  endtask

  task automatic trace_chk(input string tag, input logic [3:0] a, input logic [31:0] want);
    trace_addr = a;
    #1;
    chk(tag, trace_data, want);
  endtask

  // Start a run and step to done, optionally poking start during HOLD / RUN.
  task automatic run(input logic [31:0] exp_v, input int hold_poke, input int run_poke,
                     output int hn, output int rn);
    @(negedge clk);
    start = 1'b1; expected = exp_v;
    @(negedge clk);
    start = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_done", done, 0);
    chk("start_cycles", cycle_count, 0);
    chk("start_tcount", trace_count, 0);
    chk("start_pass", pass, 0);
    chk("start_tout", timed_out, 0);
    hn = 0;
    while (dut_reset && hn < 100) begin
      hn++;
      start    = (hn == hold_poke);
      expected = (hn == hold_poke) ? 32'h2A : exp_v;
      @(negedge clk);
    end
    start = 1'b0; expected = exp_v;
    rn = 0;
    while (!done && rn < 200) begin
      rn++;
      start    = (rn == run_poke);
      expected = (rn == run_poke) ? 32'h2A : exp_v;
      @(negedge clk);
    end
    start = 1'b0; expected = exp_v;
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; expected = 32'd0; trace_addr = 4'd0; mode = 0;
    repeat (2) @(negedge clk);
    chk("rst_dut_reset", dut_reset, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_tout", timed_out, 0);
    chk("rst_cycles", cycle_count, 0);
    chk("rst_final", final_result, 0);
    chk("rst_tcount", trace_count, 0);
    reset = 1'b1;

    // Basic pass: 1,2,3 then 0x2A.
    mode = 0;
    run(32'h2A, 0, 0, hold_n, run_n);
    chk("t1_hold", hold_n, 10);
    chk("t1_run", run_n, 7);
    chk("t1_done", done, 1);
    chk("t1_pass", pass, 1);
    chk("t1_tout", timed_out, 0);
    chk("t1_final", final_result, 32'h2A);
    chk("t1_cycles", cycle_count, 7);
    chk("t1_dut_reset", dut_reset, 1);
    chk("t1_tcount", trace_count, 7);
    trace_chk("t1_tr0", 4'd0, 32'h2A);
    trace_chk("t1_tr4", 4'd4, 32'd3);
    trace_chk("t1_tr6", 4'd6, 32'd1);

    // Mismatch, restarted from DONE, with ignored starts in HOLD and RUN.
    run(32'h2B, 3, 2, hold_n, run_n);
    chk("t2_hold", hold_n, 10);
    chk("t2_run", run_n, 7);
    chk("t2_done", done, 1);
    chk("t2_pass", pass, 0);
    chk("t2_tout", timed_out, 0);
    chk("t2_cycles", cycle_count, 7);

    // Timeout: stub never settles.
    mode = 1;
    run(32'd0, 0, 0, hold_n, run_n);
    chk("t3_run", run_n, 64);
    chk("t3_done", done, 1);
    chk("t3_cycles", cycle_count, 64);
    chk("t3_tout", timed_out, 1);
    chk("t3_pass", pass, 0);
    chk("t3_final", final_result, 63);
    trace_chk("t3_tr15", 4'd15, 32'd48);

    // Trace wrap: 0..19 then hold 19.
    mode = 2;
    run(32'd19, 0, 0, hold_n, run_n);
    chk("t4_run", run_n, 23);
    chk("t4_pass", pass, 1);
    chk("t4_tout", timed_out, 0);
    chk("t4_tcount", trace_count, 16);
    trace_chk("t4_tr0", 4'd0, 32'd19);
    trace_chk("t4_tr4", 4'd4, 32'd18);
    trace_chk("t4_tr15", 4'd15, 32'd7);

    // Async reset in the middle of RUN.
    mode = 0;
    @(negedge clk);
    start = 1'b1; expected = 32'h2A;
    @(negedge clk);
    start = 1'b0;
    hold_n = 0;
    while (dut_reset && hold_n < 100) begin
      hold_n++;
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
    chk("t6_running", dut_reset, 0);
    #2;
    reset = 1'b0;
    #1;
    chk("t6_dut_reset", dut_reset, 1);
    chk("t6_busy", busy, 0);
    chk("t6_tcount", trace_count, 0);
    chk("t6_cycles", cycle_count, 0);
    chk("t6_done", done, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("t6_idle_busy", busy, 0);
    chk("t6_idle_dut_reset", dut_reset, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

endmodule
